// File: rtl/addr_calc_pkg.sv
// addr_calc_pkg: shared FSM encoding, default sizing, width helpers and the
// kernel-height legality check for the sliding-window address generator.
package addr_calc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    localparam int unsigned DEF_MAX_W = 256;
    localparam int unsigned DEF_MAX_H = 256;
    localparam int unsigned DEF_K     = 3;

    function automatic int unsigned col_bits(input int unsigned max_w);
        return $clog2(max_w);
    endfunction

    function automatic int unsigned row_bits(input int unsigned max_h);
        return $clog2(max_h);
    endfunction

    function automatic int unsigned buf_bits(input int unsigned k);
        return $clog2(k + 1);
    endfunction

    localparam int unsigned DEF_CW = col_bits(DEF_MAX_W);
    localparam int unsigned DEF_RW = row_bits(DEF_MAX_H);
    localparam int unsigned DEF_BW = buf_bits(DEF_K);

    // Only odd window heights 3, 5 and 7 are supported
    function automatic bit k_legal(input int unsigned k);
        return (k == 3) || (k == 5) || (k == 7);
    endfunction

endpackage

// File: rtl/addr_calc_dma_win_wrap_cnt.sv
// wrap_cnt: up-counter with synchronous clear, enable, runtime wrap limit
// and a same-cycle wrap pulse (count at limit while enabled).
module wrap_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap_o = en_i && (cnt_q == limit_i);
    assign cnt_o  = cnt_q;

    // Next count: clear wins, otherwise step and return to zero at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == limit_i) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/addr_calc_dma_win.sv
// addr_calc_dma_win: write/read address generator for K+1 rotating line
// buffers feeding K-row vertical windows, with a self-timed drain row.
// Optional sticky err output when ADDR_CALC_DMA_ERR_EN is defined.
module addr_calc_dma_win
    import addr_calc_pkg::*;
#(
    parameter int unsigned MAX_W = DEF_MAX_W,
    parameter int unsigned MAX_H = DEF_MAX_H,
    parameter int unsigned K     = DEF_K,
    localparam int unsigned CW   = col_bits(MAX_W),
    localparam int unsigned RW   = row_bits(MAX_H),
    localparam int unsigned BW   = buf_bits(K)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW:0]   img_w,
    input  logic [RW:0]   img_h,
    input  logic          we_in,
    output logic          busy,
    output logic          wr_en,
    output logic [K:0]    wbuf_onehot,
    output logic [CW-1:0] waddr,
    output logic          re,
    output logic [CW-1:0] raddr,
    output logic [BW-1:0] rd_base,
    output logic          we_out,
    output logic [CW-1:0] col_cnt,
    output logic [RW-1:0] row_cnt,
    output logic          done
`ifdef ADDR_CALC_DMA_ERR_EN
    ,
    output logic          err
`endif
);

    localparam bit            K_OK      = k_legal(K);
    localparam logic [CW:0]   W_MAX     = MAX_W[CW:0];
    localparam logic [RW:0]   H_MAX     = MAX_H[RW:0];
    localparam logic [RW:0]   H_MIN     = K[RW:0];
    localparam logic [RW-1:0] K_ROW     = K[RW-1:0];
    localparam int unsigned   KM1       = K - 1;
    localparam logic [RW-1:0] LOAD_LAST = KM1[RW-1:0];
    localparam logic [BW-1:0] BUF_LAST  = K[BW-1:0];

    state_e        state_q, state_d;
    logic [CW-1:0] col_lim_q, col_lim_d;
    logic [RW-1:0] row_lim_q, row_lim_d;
    logic [RW-1:0] drain_row_q, drain_row_d;
    logic          we_out_q, we_out_d;
    logic [CW-1:0] col_out_q, col_out_d;
    logic [RW-1:0] row_out_q, row_out_d;
    logic          done_q, done_d;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [BW-1:0] wbuf_idx;
    logic [BW-1:0] rdb_idx;
    logic          col_wrap, row_wrap;
    logic          wbuf_wrap_unused, rdb_wrap_unused;
    logic          wr_state, rd_state;
    logic          col_en, row_en, rdb_en;
    logic          dims_ok, accept;

    assign dims_ok = K_OK && (img_w != '0) && (img_w <= W_MAX) &&
                     (img_h >= H_MIN) && (img_h <= H_MAX);
    // The done cycle still counts as busy, so a start there is ignored
    assign accept  = (state_q == IDLE) && !done_q && start && dims_ok;

    assign col_en = wr_en | re;
    assign row_en = wr_en & col_wrap;
    assign rdb_en = row_en & (state_q == STREAM);

    wrap_cnt #(.W(CW)) u_col (
        .clk(clk), .rst_n(rst_n), .clr_i(accept), .en_i(col_en),
        .limit_i(col_lim_q), .cnt_o(col), .wrap_o(col_wrap)
    );

    wrap_cnt #(.W(RW)) u_row (
        .clk(clk), .rst_n(rst_n), .clr_i(accept), .en_i(row_en),
        .limit_i(row_lim_q), .cnt_o(row), .wrap_o(row_wrap)
    );

    wrap_cnt #(.W(BW)) u_wbuf (
        .clk(clk), .rst_n(rst_n), .clr_i(accept), .en_i(row_en),
        .limit_i(BUF_LAST), .cnt_o(wbuf_idx), .wrap_o(wbuf_wrap_unused)
    );

    // Advances once per completed STREAM row, so in DRAIN it already holds
    // (img_h-K) mod (K+1) without any division
    wrap_cnt #(.W(BW)) u_rdb (
        .clk(clk), .rst_n(rst_n), .clr_i(accept), .en_i(rdb_en),
        .limit_i(BUF_LAST), .cnt_o(rdb_idx), .wrap_o(rdb_wrap_unused)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD: begin
                if (row_wrap)                             state_d = DRAIN;
                else if (row_en && (row == LOAD_LAST))    state_d = STREAM;
            end
            STREAM:  if (row_wrap) state_d = DRAIN;
            DRAIN:   if (col_wrap) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: write/read strobes and phase qualifiers
    always_comb begin
        wr_state = 1'b0;
        rd_state = 1'b0;
        wr_en    = 1'b0;
        re       = 1'b0;
        case (state_q)
            LOAD: begin
                wr_state = 1'b1;
                wr_en    = we_in;
            end
            STREAM: begin
                wr_state = 1'b1;
                rd_state = 1'b1;
                wr_en    = we_in;
                re       = we_in;
            end
            DRAIN: begin
                rd_state = 1'b1;
                re       = 1'b1;
            end
            default: ;
        endcase
    end

    // Write-buffer select, one-hot over the K+1 buffers
    always_comb begin
        wbuf_onehot = '0;
        for (int unsigned i = 0; i <= K; i++) begin
            wbuf_onehot[i] = wr_state && (wbuf_idx == i[BW-1:0]);
        end
    end

    assign waddr   = wr_state ? col : '0;
    assign raddr   = rd_state ? col : '0;
    assign rd_base = rd_state ? rdb_idx : '0;
    assign busy    = (state_q != IDLE) || done_q;
    assign we_out  = we_out_q;
    assign col_cnt = col_out_q;
    assign row_cnt = row_out_q;
    assign done    = done_q;

    // Frame geometry latched at start, kept as wrap limits and drain row
    always_comb begin
        col_lim_d   = col_lim_q;
        row_lim_d   = row_lim_q;
        drain_row_d = drain_row_q;
        if (accept) begin
            col_lim_d   = img_w[CW-1:0] - 1'b1;
            row_lim_d   = img_h[RW-1:0] - 1'b1;
            drain_row_d = img_h[RW-1:0] - K_ROW;
        end
    end

    // Window-column outputs follow the read by one cycle
    always_comb begin
        we_out_d  = re;
        done_d    = (state_q == DRAIN) && col_wrap;
        col_out_d = col_out_q;
        row_out_d = row_out_q;
        if (accept) begin
            col_out_d = '0;
            row_out_d = '0;
        end else if (re) begin
            col_out_d = col;
            row_out_d = (state_q == DRAIN) ? drain_row_q : row - K_ROW;
        end
    end

    // Geometry and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_lim_q   <= '0;
            row_lim_q   <= '0;
            drain_row_q <= '0;
            we_out_q    <= 1'b0;
            col_out_q   <= '0;
            row_out_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            col_lim_q   <= col_lim_d;
            row_lim_q   <= row_lim_d;
            drain_row_q <= drain_row_d;
            we_out_q    <= we_out_d;
            col_out_q   <= col_out_d;
            row_out_q   <= row_out_d;
            done_q      <= done_d;
        end
    end

`ifdef ADDR_CALC_DMA_ERR_EN
    logic err_q, err_d;

    // Sticky misuse flag, cleared only by an accepted start
    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if ((start && (busy || !dims_ok)) || (we_in && !wr_state)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_addr_calc_dma_win.sv
// Directed self-checking bench for addr_calc_dma_win (K=3 and K=5 instances).
module tb_addr_calc_dma_win;
    import addr_calc_pkg::*;

    localparam int unsigned CW = DEF_CW;
    localparam int unsigned RW = DEF_RW;
    localparam int unsigned BW = DEF_BW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // K=3 instance
    logic          start, we_in, busy, wr_en, re, we_out, done;
    logic [CW:0]   img_w;
    logic [RW:0]   img_h;
    logic [3:0]    wbuf_onehot;
    logic [CW-1:0] waddr, raddr, col_cnt;
    logic [BW-1:0] rd_base;
    logic [RW-1:0] row_cnt;

    // K=5 instance
    logic          start5, we_in5, busy5, wr_en5, re5, we_out5, done5;
    logic [CW:0]   img_w5;
    logic [RW:0]   img_h5;
    logic [5:0]    wbuf5;
    logic [CW-1:0] waddr5, raddr5, col5;
    logic [2:0]    rd_base5;
    logic [RW-1:0] row5;

`ifdef ADDR_CALC_DMA_ERR_EN
    logic err, err5;
`endif

    addr_calc_dma_win #(.MAX_W(256), .MAX_H(256), .K(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .img_w(img_w), .img_h(img_h),
        .we_in(we_in), .busy(busy), .wr_en(wr_en), .wbuf_onehot(wbuf_onehot),
        .waddr(waddr), .re(re), .raddr(raddr), .rd_base(rd_base),
        .we_out(we_out), .col_cnt(col_cnt), .row_cnt(row_cnt), .done(done)
`ifdef ADDR_CALC_DMA_ERR_EN
        , .err(err)
`endif
    );

    addr_calc_dma_win #(.MAX_W(256), .MAX_H(256), .K(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .img_w(img_w5), .img_h(img_h5),
        .we_in(we_in5), .busy(busy5), .wr_en(wr_en5), .wbuf_onehot(wbuf5),
        .waddr(waddr5), .re(re5), .raddr(raddr5), .rd_base(rd_base5),
        .we_out(we_out5), .col_cnt(col5), .row_cnt(row5), .done(done5)
`ifdef ADDR_CALC_DMA_ERR_EN
        , .err(err5)
`endif
    );

    int n_chk = 0;
    int n_err = 0;
    int wo_n;
    int prev_re;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One cycle on the K=3 instance: check combinational outputs at negedge
    task automatic sample(input int e_wr, input int e_wa, input int e_oh, input int e_re,
                          input int e_ra, input int e_rb, input int e_busy,
                          input int w, input int total);
        @(negedge clk);
        chk("wr_en", wr_en, e_wr);
        if (e_wr != 0) begin
            chk("waddr", waddr, e_wa);
            chk("wbuf_onehot", wbuf_onehot, e_oh);
        end
        chk("re", re, e_re);
        if (e_re != 0) begin
            chk("raddr", raddr, e_ra);
            chk("rd_base", rd_base, e_rb);
        end
        chk("busy", busy, e_busy);
        chk("we_out", we_out, prev_re);
        if (we_out === 1'b1) begin
            chk("col_cnt", col_cnt, wo_n % w);
            chk("row_cnt", row_cnt, wo_n / w);
            chk("done", done, (wo_n == total - 1));
            wo_n++;
        end else begin
            chk("done_idle", done, 0);
        end
        prev_re = e_re;
    endtask

    // Full frame on the K=3 instance; gap idle cycles before every pixel
    task automatic run_frame(input int w, input int h, input int gap);
        int total;
        total   = w * (h - 3 + 1);
        wo_n    = 0;
        prev_re = 0;
        img_w = w[CW:0];
        img_h = h[RW:0];
        we_in = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                for (int g = 0; g < gap; g++) begin
                    we_in = 1'b0;
                    sample(0, 0, 0, 0, 0, 0, 1, w, total);
                    @(posedge clk); #1;
                end
                we_in = 1'b1;
                sample(1, c, 1 << (r % 4), (r >= 3), c, (r >= 3) ? (r - 3) % 4 : 0, 1, w, total);
`ifdef ADDR_CALC_DMA_ERR_EN
                if (r == 0 && c == 0) chk("err_cleared", err, 0);
`endif
                @(posedge clk); #1;
            end
        end
        for (int c = 0; c < w; c++) begin
            we_in = (gap == 0);
            sample(0, 0, 0, 1, c, (h - 3) % 4, 1, w, total);
            @(posedge clk); #1;
        end
        we_in = 1'b0;
        sample(0, 0, 0, 0, 0, 0, 1, w, total);
        @(posedge clk); #1;
        sample(0, 0, 0, 0, 0, 0, 0, w, total);
        chk("we_out_total", wo_n, total);
        @(posedge clk); #1;
    endtask

    initial begin
        int n5;
        rst_n = 1'b0;
        start = 1'b0; we_in = 1'b0; img_w = '0; img_h = '0;
        start5 = 1'b0; we_in5 = 1'b0; img_w5 = '0; img_h5 = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_wbuf", wbuf_onehot, 0);
        chk("rst_rd_base", rd_base, 0);
        chk("rst_we_out", we_out, 0);
        chk("rst_done", done, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_wr_en", wr_en, 0);

        // Rejected starts: height below K, then zero width
        img_w = 9'd8; img_h = 9'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("rej_h_busy", busy, 0);
        @(posedge clk); #1;
        img_w = 9'd0; img_h = 9'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; we_in = 1'b1;
        @(negedge clk);
        chk("rej_w_busy", busy, 0);
        chk("idle_we_in_wr_en", wr_en, 0);
        chk("idle_we_in_re", re, 0);
`ifdef ADDR_CALC_DMA_ERR_EN
        chk("rej_err", err, 1);
`endif
        @(posedge clk); #1;
        we_in = 1'b0;

        run_frame(8, 4, 0);
        run_frame(8, 4, 2);
        run_frame(1, 3, 0);

        // Reset in STREAM at row 3, column 4
        img_w = 9'd8; img_h = 9'd4; start = 1'b1; we_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 28; i++) begin
            we_in = 1'b1;
            @(posedge clk); #1;
        end
        #1;
        chk("pre_rst_re", re, 1);
        chk("pre_rst_raddr", raddr, 4);
        chk("pre_rst_we_out", we_out, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_wbuf", wbuf_onehot, 0);
        chk("mid_rst_waddr", waddr, 0);
        chk("mid_rst_re", re, 0);
        chk("mid_rst_raddr", raddr, 0);
        chk("mid_rst_rd_base", rd_base, 0);
        chk("mid_rst_we_out", we_out, 0);
        chk("mid_rst_col", col_cnt, 0);
        chk("mid_rst_row", row_cnt, 0);
        chk("mid_rst_done", done, 0);
        we_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(8, 4, 0);

        // K=5, 6x7 frame
        n5 = 0;
        img_w5 = 9'd6; img_h5 = 9'd7; start5 = 1'b1;
        @(posedge clk); #1;
        start5 = 1'b0;
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 6; c++) begin
                we_in5 = 1'b1;
                @(negedge clk);
                if (we_out5 === 1'b1) n5++;
                chk("k5_wbuf", wbuf5, 1 << (r % 6));
                chk("k5_re", re5, (r >= 5));
                if (r >= 5) chk("k5_rd_base", rd_base5, r - 5);
                @(posedge clk); #1;
            end
        end
        we_in5 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (we_out5 === 1'b1) n5++;
            chk("k5_drain_re", re5, 1);
            chk("k5_drain_raddr", raddr5, c);
            chk("k5_drain_rd_base", rd_base5, 2);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("k5_last_we_out", we_out5, 1);
        chk("k5_done", done5, 1);
        chk("k5_last_row", row5, 2);
        chk("k5_last_col", col5, 5);
        if (we_out5 === 1'b1) n5++;
        chk("k5_we_out_total", n5, 18);
        @(posedge clk); #1;
        @(negedge clk);
        chk("k5_busy_after", busy5, 0);
        @(posedge clk); #1;

        run_frame(256, 256, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
